// File: rtl/sha_block_padder.sv
// sha_block_padder
//   Packs a stream of 32-bit big-endian message words into 512-bit SHA-256
//   blocks, appends the standard padding (0x80, zero fill, 64-bit big-endian
//   bit length) and hands blocks downstream one at a time with first/last
//   flags (first selects the IV, last marks the final digest).
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_data    message word, byte 0 in [31:24], byte 3 in [7:0]
//   in_valid   in_data/in_last/in_bytes valid
//   in_last    final word of the message
//   in_bytes   valid bytes in the final word (0..4), ignored when in_last=0
//   in_ready   a word is accepted this cycle when in_valid is also high
//   out_block  word i at [32i+31:32i]; word 0 holds the first message bytes
//   out_valid  out_block valid
//   out_first  block is the first block of its message
//   out_last   block is the final block of its message
//   out_ready  downstream consumes the block this cycle
module sha_block_padder (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         in_ready,
  output logic [511:0] out_block,
  output logic         out_valid,
  output logic         out_first,
  output logic         out_last,
  input  logic         out_ready
);

  localparam logic [1:0] S_FILL       = 2'd0;
  localparam logic [1:0] S_EMIT       = 2'd1;
  localparam logic [1:0] S_PAD        = 2'd2;
  localparam logic [1:0] S_EMIT_FINAL = 2'd3;

  logic [1:0]  state_q;
  logic [3:0]  idx_q;
  logic [31:0] words_q [16];
  logic [63:0] len_q;
  logic        first_pending_q;
  logic        pad_pending_q;   // a length-only block must follow the current one
  logic        spill_full_q;    // that extra block also starts with the 0x80 byte

  logic [2:0]  n_bytes;
  logic [31:0] keep_mask;
  logic [31:0] pad_word;
  logic [6:0]  pad_pos;
  logic [63:0] len_next;
  logic        accept;

  always_comb begin
    n_bytes = 3'd4;
    if (in_last && (in_bytes < 3'd4)) n_bytes = in_bytes;
    keep_mask = ~(32'hFFFF_FFFF >> {n_bytes, 3'b000});
    pad_word  = '0;
    if (n_bytes != 3'd4) pad_word = 32'h8000_0000 >> {n_bytes, 3'b000};
    pad_pos  = {1'b0, idx_q, 2'b00} + {4'b0000, n_bytes};
    len_next = len_q + {58'd0, n_bytes, 3'b000};
  end

  assign out_valid = (state_q == S_EMIT) || (state_q == S_EMIT_FINAL);
  assign out_first = out_valid && first_pending_q;
  assign out_last  = (state_q == S_EMIT_FINAL);
  assign in_ready  = reset && (state_q == S_FILL);
  assign accept    = in_valid && in_ready;

  always_comb begin
    out_block = '0;
    for (int unsigned i = 0; i < 16; i++) out_block[32*i +: 32] = words_q[4'(i)];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_FILL;
      idx_q           <= '0;
      len_q           <= '0;
      first_pending_q <= 1'b1;
      pad_pending_q   <= 1'b0;
      spill_full_q    <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) words_q[4'(i)] <= '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (accept) begin
            if (!in_last) begin
              words_q[idx_q] <= in_data;
              len_q          <= len_q + 64'd32;
              if (idx_q == 4'd15) state_q <= S_EMIT;
              else                idx_q   <= idx_q + 4'd1;
            end else begin
              words_q[idx_q] <= (in_data & keep_mask) | pad_word;
              len_q          <= len_next;
              // A full last word pushes the 0x80 byte into the next word.
              if ((n_bytes == 3'd4) && (idx_q != 4'd15))
                words_q[idx_q + 4'd1] <= 32'h8000_0000;
              if (pad_pos <= 7'd55) begin
                words_q[14] <= len_next[63:32];
                words_q[15] <= len_next[31:0];
                state_q     <= S_EMIT_FINAL;
              end else begin
                pad_pending_q <= 1'b1;
                spill_full_q  <= (pad_pos == 7'd64);
                state_q       <= S_EMIT;
              end
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            for (int unsigned i = 0; i < 16; i++) words_q[4'(i)] <= '0;
            idx_q           <= '0;
            first_pending_q <= 1'b0;
            state_q         <= pad_pending_q ? S_PAD : S_FILL;
          end
        end
        S_PAD: begin
          for (int unsigned i = 0; i < 16; i++) words_q[4'(i)] <= '0;
          words_q[0]    <= spill_full_q ? 32'h8000_0000 : 32'h0000_0000;
          words_q[14]   <= len_q[63:32];
          words_q[15]   <= len_q[31:0];
          pad_pending_q <= 1'b0;
          spill_full_q  <= 1'b0;
          state_q       <= S_EMIT_FINAL;
        end
        default: begin // S_EMIT_FINAL
          if (out_ready) begin
            for (int unsigned i = 0; i < 16; i++) words_q[4'(i)] <= '0;
            idx_q           <= '0;
            first_pending_q <= 1'b1;
            len_q           <= '0;
            state_q         <= S_FILL;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_block_padder.sv
// tb_sha_block_padder
//   Directed bench for sha_block_padder. Each message's expected blocks are
//   produced by a byte-level padding model and queued; a monitor pops and
//   compares them as blocks are transferred.
module tb_sha_block_padder;

  logic         clk;
  logic         reset;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         in_ready;
  logic [511:0] out_block;
  logic         out_valid;
  logic         out_first;
  logic         out_last;
  logic         out_ready;

  typedef byte unsigned msg_t [$];
  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  sha_block_padder dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .in_ready  (in_ready),
    .out_block (out_block),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Textbook SHA-256 padding on a byte array, then split into blocks.
  function automatic void model_push(input msg_t msg);
    msg_t        p;
    logic [63:0] bl;
    int          nb;
    exp_t        e;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.blk = '0;
      for (int i = 0; i < 16; i++)
        e.blk[32*i +: 32] = {p[64*b+4*i], p[64*b+4*i+1], p[64*b+4*i+2], p[64*b+4*i+3]};
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      sb.push_back(e);
    end
  endfunction

  function automatic msg_t str_msg(input string s);
    msg_t m;
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    return m;
  endfunction

  function automatic msg_t rand_msg(input int len);
    msg_t m;
    for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
    return m;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    bit got;
    got      = 1'b0;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    in_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("in_ready_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input msg_t msg, input bit push);
    int          len;
    int          nw;
    logic [31:0] w;
    len = msg.size();
    nw  = (len == 0) ? 1 : (len + 3) / 4;
    if (push) model_push(msg);
    for (int k = 0; k < nw; k++) begin
      w = $urandom;  // bytes past the end of the message are junk
      for (int j = 0; j < 4; j++)
        if (4*k + j < len) w[31-8*j -: 8] = msg[4*k+j];
      if (k == nw - 1) send_word(w, 1'b1, 3'(len - 4*k));
      else             send_word(w, 1'b0, 3'd4);
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    @(posedge clk);
    #1;
    check(tag, 512'(sb.size()), '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_block", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("blk", out_block, e.blk);
        check("first", out_first, e.first);
        check("last", out_last, e.last);
      end
    end
  end

  initial begin
    logic [511:0] cap;
    int lens [9] = '{0, 3, 52, 55, 56, 60, 63, 64, 130};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_bytes  = '0;
    out_ready = 1'b1;
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_block", out_block, '0);
    check("rst_out_first", out_first, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("fill_in_ready", in_ready, 1'b1);

    // "hello world": block visible right after the accepting edge
    send_msg(str_msg("hello world"), 1'b1);
    check("hello_latency", out_valid, 1'b1);
    wait_drain("hello_drain");

    send_msg(str_msg(""), 1'b1);
    check("empty_word0", out_block[31:0], 32'h8000_0000);
    wait_drain("empty_drain");

    foreach (lens[i]) begin
      send_msg(rand_msg(lens[i]), 1'b1);
      wait_drain($sformatf("len%0d_drain", lens[i]));
    end

    // Backpressure with junk on the input side
    out_ready = 1'b0;
    send_msg(str_msg("hello world"), 1'b1);
    #1;
    cap = out_block;
    check("bp_word2", out_block[95:64], 32'h726C_6480);
    check("bp_word15", out_block[511:480], 32'h0000_0058);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_last  = c[0];
      in_data  = $urandom;
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_valid", out_valid, 1'b1);
      check("bp_block_stable", out_block, cap);
      check("bp_flags", {out_first, out_last}, 2'b11);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    wait_drain("bp_drain");
    send_msg(str_msg("abc"), 1'b1);
    wait_drain("bp_after_drain");

    // Reset while a block is waiting in EMIT
    out_ready = 1'b0;
    send_msg(rand_msg(64), 1'b0);
    check("emit_valid", out_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    send_msg(str_msg("abc"), 1'b1);
    check("abc_word0", out_block[31:0], 32'h6162_6380);
    check("abc_word15", out_block[511:480], 32'h0000_0018);
    wait_drain("abc_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha_block_padder.md
Name: sha_block_padder

Overview:
- Upstream feeder for the SHA-256 block processor. Accepts a message as a stream of 32-bit big-endian words with valid/ready handshaking.
- Packs the words into 512-bit blocks, appends the SHA-256 padding (0x80, zero fill, 64-bit big-endian bit length) and emits one block at a time.
- Emitted blocks carry first/last flags. The controller downstream uses first to select the IV versus the chained hash, and last to mark the final digest.

Parameters:
- None. Block width 512 and word width 32 are fixed by SHA-256.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_data  in  32  message word; byte 0 of the word in [31:24], byte 3 in [7:0]
- in_valid  in  1  in_data/in_last/in_bytes valid
- in_last  in  1  this is the final word of the message
- in_bytes  in  3  valid bytes in the word, 1..4; 0 is legal only with in_last (zero-byte tail); ignored (treated as 4) when in_last=0
- in_ready  out  1  padder accepts a word this cycle
- out_block  out  512  word i at [32i+31:32i]; word 0 holds the first message bytes, word 15 holds len[31:0]
- out_valid  out  1  out_block valid
- out_first  out  1  block is the first block of its message
- out_last  out  1  block is the final block of its message
- out_ready  in  1  downstream consumes the block this cycle

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset=0).
- While reset=0:
  - state = FILL, word index = 0, buffer = 0, bit-length counter = 0, first_pending = 1.
  - Outputs: out_valid = 0, out_first = 0, out_last = 0, out_block = 0.
  - in_ready is 0 while reset=0 and is 1 in FILL after reset releases.
- Reset mid-operation: asserting reset in any state aborts the message immediately. out_valid drops asynchronously. The next accepted word starts a new message with out_first = 1.
- States:
  - FILL: in_ready = 1; one word accepted per in_valid && in_ready cycle.
  - EMIT: out_valid = 1, in_ready = 0.
  - PAD: builds the extra length-only block, 1 cycle, in_ready = 0.
  - EMIT_FINAL: out_valid = 1, out_last = 1, in_ready = 0.
- FILL, non-last word:
  - Write in_data to word[idx] and add 32 to the length counter.
  - If idx == 15, go to EMIT with out_last = 0; otherwise idx += 1.
- FILL, last word (n = in_bytes):
  - Keep the top n bytes of in_data and force the lower bytes to 0. Add 8*n to the length.
  - Padding byte offset p = 4*idx + n, range 0..64.
  - If p < 64, byte p is 0x80. Bytes after p up to byte 55 are 0.
  - If p <= 55: word14 = len[63:32], word15 = len[31:0] (the updated length). Go to EMIT_FINAL.
  - If 56 <= p <= 63: the remaining bytes are 0 and no length is written. Go to EMIT; the handshake then leads to PAD.
  - If p == 64: the block is all data. Go to EMIT; PAD then places 0x80 at byte 0 of the next block.
- PAD: clear the buffer, set byte 0 = 0x80 only if p was 64, write the length into words 14/15, go to EMIT_FINAL.
- Output handshake:
  - out_block, out_first and out_last are held stable while out_valid && !out_ready.
  - Transfer occurs on out_valid && out_ready.
  - After a transfer from EMIT (non-final), clear the buffer, set idx = 0, first_pending = 0, and return to FILL, or go to PAD if a padding spill is pending.
  - After a transfer from EMIT_FINAL, clear the buffer, set first_pending = 1, clear the length, and return to FILL.
  - Each state returns to FILL on the cycle after the transfer. A new word cannot be accepted in the same cycle as a block transfer.
- out_first = first_pending for every emitted block. A single-block message has first = last = 1.
- The length counter is 64 bits and wraps modulo 2^64 with no error flag.
- in_data is ignored whenever in_ready = 0. Upstream must hold in_valid and its data until in_ready is asserted.
- Latency: the block appears 1 cycle after the accepting edge of its 16th word or last word. PAD adds 1 cycle.

Test Plan:
- "hello world" (11 bytes):
  - Stimulus: 68656C6C, 6F20776F, 726C64xx with in_last=1, in_bytes=3.
  - Response: one block, first = last = 1. word0 = 68656C6C, word1 = 6F20776F, word2 = 726C6480, words 3..14 = 0, word15 = 00000058.
- Empty message:
  - Stimulus: a single word with in_last=1, in_bytes=0.
  - Response: word0 = 80000000, all other words 0, word15 = 0, first = last = 1.
- 56-byte message:
  - Stimulus: 14 full words, last has in_bytes=4.
  - Block 1: data in words 0..13, word14 = 80000000, word15 = 0; first = 1, last = 0.
  - Block 2: words 0..14 = 0, word15 = 000001C0; first = 0, last = 1.
- 64-byte message:
  - Stimulus: 16 words, last has in_bytes=4.
  - Block 1: all data; first = 1, last = 0.
  - Block 2: word0 = 80000000, word15 = 00000200; last = 1.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 5 cycles while out_valid = 1 and toggle in_data.
  - Response: out_block and flags stable, in_ready = 0, no words lost. The result matches the unstalled run.
- Reset during EMIT:
  - Stimulus: assert reset while out_valid = 1 mid-message, release, then send "abc" (61626300, in_bytes=3).
  - Response: out_valid drops immediately. Next block has first = 1, last = 1, word0 = 61626380, word15 = 00000018.
